// File: rtl/calc_sequencer.sv
// rtl/calc_sequencer.sv - calculator operand/opcode entry sequencer with ALU handshake; optional backspace via CALC_SEQ_BACKSPACE_EN
module calc_sequencer #(
    parameter int DIGITS      = 4,
    parameter int DIGIT_W     = 4,
    parameter int OP_W        = 2,
    parameter int ALU_TIMEOUT = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         exe,
    input  logic                         button,
`ifdef CALC_SEQ_BACKSPACE_EN
    input  logic                         del,
`endif
    input  logic [DIGIT_W-1:0]           digit_in,
    input  logic [OP_W-1:0]              op_in,
    input  logic                         alu_done,
    output logic [DIGITS*DIGIT_W-1:0]    alu_a,
    output logic [DIGITS*DIGIT_W-1:0]    alu_b,
    output logic [OP_W-1:0]              alu_op,
    output logic                         alu_start,
    output logic                         result_valid,
    output logic                         error,
    output logic [$clog2(DIGITS+1)-1:0]  digit_cnt,
    output logic [1:0]                   estado
);

    localparam int OPND_W = DIGITS * DIGIT_W;
    localparam int CNT_W  = $clog2(DIGITS + 1);
    localparam int TMR_W  = $clog2(ALU_TIMEOUT);

    typedef enum logic [2:0] {
        S_ENTER_A = 3'd0,
        S_ENTER_B = 3'd1,
        S_SEL_OP  = 3'd2,
        S_RUN     = 3'd3,
        S_SHOW    = 3'd4,
        S_ERR     = 3'd5
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic               exe_q;
    logic               button_q;
    logic               ex_r;
    logic               bt_r;
    logic               in_entry;
    logic               take_digit;
    logic               clear_all;
    logic [TMR_W-1:0]   timer;

    assign ex_r = exe & ~exe_q;
    assign bt_r = button & ~button_q;

    assign in_entry  = (state_q == S_ENTER_A) || (state_q == S_ENTER_B);
    assign clear_all = ((state_q == S_SHOW) || (state_q == S_ERR)) && ex_r;

`ifdef CALC_SEQ_BACKSPACE_EN
    logic del_q;
    logic del_r;
    logic take_del;

    assign del_r      = del & ~del_q;
    assign take_del   = in_entry && del_r && !ex_r && (digit_cnt != '0);
    // exe beats backspace, backspace beats a digit press
    assign take_digit = in_entry && bt_r && !ex_r && !del_r && (digit_cnt < CNT_W'(DIGITS));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            del_q <= 1'b0;
        end else begin
            del_q <= del;
        end
    end
`else
    assign take_digit = in_entry && bt_r && !ex_r && (digit_cnt < CNT_W'(DIGITS));
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_ENTER_A;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_ENTER_A: if (ex_r) state_d = S_ENTER_B;
            S_ENTER_B: if (ex_r) state_d = S_SEL_OP;
            S_SEL_OP:  if (ex_r) state_d = S_RUN;
            S_RUN: begin
                // done takes precedence over a coincident timeout
                if (alu_done)                                state_d = S_SHOW;
                else if (timer == TMR_W'(ALU_TIMEOUT - 1))   state_d = S_ERR;
            end
            S_SHOW:    if (ex_r) state_d = S_ENTER_A;
            S_ERR:     if (ex_r) state_d = S_ENTER_A;
            default:   state_d = S_ENTER_A;
        endcase
    end

    always_comb begin
        estado = 2'd0;
        case (state_q)
            S_ENTER_A:      estado = 2'd0;
            S_ENTER_B:      estado = 2'd1;
            S_SEL_OP, S_RUN: estado = 2'd2;
            S_SHOW, S_ERR:  estado = 2'd3;
            default:        estado = 2'd0;
        endcase
    end

    assign result_valid = (state_q == S_SHOW);
    assign error        = (state_q == S_ERR);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            exe_q     <= 1'b0;
            button_q  <= 1'b0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_op    <= '0;
            alu_start <= 1'b0;
            digit_cnt <= '0;
            timer     <= '0;
        end else begin
            exe_q     <= exe;
            button_q  <= button;
            alu_start <= (state_q == S_SEL_OP) && ex_r;
            timer     <= (state_q == S_RUN) ? timer + 1'b1 : '0;

            if (clear_all) begin
                alu_a     <= '0;
                alu_b     <= '0;
                alu_op    <= '0;
                digit_cnt <= '0;
            end else if (in_entry && ex_r) begin
                digit_cnt <= '0;
            end else if (take_digit) begin
                if (state_q == S_ENTER_A) alu_a <= (alu_a << DIGIT_W) | OPND_W'(digit_in);
                else                      alu_b <= (alu_b << DIGIT_W) | OPND_W'(digit_in);
                digit_cnt <= digit_cnt + 1'b1;
            end
`ifdef CALC_SEQ_BACKSPACE_EN
            else if (take_del) begin
                if (state_q == S_ENTER_A) alu_a <= alu_a >> DIGIT_W;
                else                      alu_b <= alu_b >> DIGIT_W;
                digit_cnt <= digit_cnt - 1'b1;
            end
`endif

            if ((state_q == S_SEL_OP) && bt_r && !ex_r) begin
                alu_op <= op_in;
            end
        end
    end

endmodule

// File: tb/tb_calc_sequencer.sv
// tb/tb_calc_sequencer.sv - directed self-checking bench for calc_sequencer
module tb_calc_sequencer;

    logic        clk;
    logic        rst;
    logic        exe;
    logic        button;
    logic        del;
    logic [3:0]  digit_in;
    logic [1:0]  op_in;
    logic        alu_done;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [1:0]  alu_op;
    logic        alu_start;
    logic        result_valid;
    logic        error;
    logic [2:0]  digit_cnt;
    logic [1:0]  estado;

    int checks = 0;
    int errors = 0;

    calc_sequencer dut (
        .clk          (clk),
        .rst          (rst),
        .exe          (exe),
        .button       (button),
`ifdef CALC_SEQ_BACKSPACE_EN
        .del          (del),
`endif
        .digit_in     (digit_in),
        .op_in        (op_in),
        .alu_done     (alu_done),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_op       (alu_op),
        .alu_start    (alu_start),
        .result_valid (result_valid),
        .error        (error),
        .digit_cnt    (digit_cnt),
        .estado       (estado)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic press_digit(input logic [3:0] d);
        digit_in = d;
        button   = 1'b1;
        tick();
        button   = 1'b0;
        tick();
    endtask

    task automatic press_exe();
        exe = 1'b1;
        tick();
        exe = 1'b0;
        tick();
    endtask

    initial begin
        rst = 1'b0; exe = 1'b0; button = 1'b0; del = 1'b0;
        digit_in = '0; op_in = '0; alu_done = 1'b0;
        tick();
        tick();
        check("reset_estado", 32'(estado), 32'd0);
        check("reset_alu_a", 32'(alu_a), 32'd0);
        check("reset_error", 32'(error), 32'd0);
        rst = 1'b1;
        tick();

        // Reset asserted while in RUN
        press_digit(4'h9);
        press_exe();
        press_exe();
        press_exe();
        check("run_estado", 32'(estado), 32'd2);
        rst = 1'b0;
        tick();
        check("rst_run_estado", 32'(estado), 32'd0);
        check("rst_run_alu_a", 32'(alu_a), 32'd0);
        check("rst_run_alu_op", 32'(alu_op), 32'd0);
        check("rst_run_start", 32'(alu_start), 32'd0);
        check("rst_run_valid", 32'(result_valid), 32'd0);
        rst = 1'b1;
        tick();

        // Operand A with saturation at four digits
        press_digit(4'h1);
        press_digit(4'h2);
        press_digit(4'h3);
        press_digit(4'h4);
        press_digit(4'h5);
        check("a_value", 32'(alu_a), 32'h1234);
        check("a_cnt_sat", 32'(digit_cnt), 32'd4);
        press_exe();
        check("a_exe_estado", 32'(estado), 32'd1);
        check("a_exe_cnt", 32'(digit_cnt), 32'd0);

        // Operand B, opcode, normal ALU handshake
        press_digit(4'h5);
        press_digit(4'h6);
        check("b_value", 32'(alu_b), 32'h0056);
        press_exe();
        check("selop_estado", 32'(estado), 32'd2);
        check("selop_no_start", 32'(alu_start), 32'd0);
        op_in = 2'b10;
        press_digit(4'h0);
        check("op_value", 32'(alu_op), 32'd2);
        exe = 1'b1;
        tick();
        exe = 1'b0;
        check("start_first", 32'(alu_start), 32'd1);
        tick();
        check("start_second", 32'(alu_start), 32'd0);
        tick();
        alu_done = 1'b1;
        tick();
        alu_done = 1'b0;
        check("show_valid", 32'(result_valid), 32'd1);
        check("show_estado", 32'(estado), 32'd3);
        check("show_alu_a", 32'(alu_a), 32'h1234);
        press_exe();
        check("show_exit_estado", 32'(estado), 32'd0);
        check("show_exit_alu_a", 32'(alu_a), 32'd0);
        check("show_exit_alu_b", 32'(alu_b), 32'd0);
        check("show_exit_alu_op", 32'(alu_op), 32'd0);

        // Timeout: error exactly 16 cycles after alu_start
        press_exe();
        press_exe();
        exe = 1'b1;
        tick();
        exe = 1'b0;
        check("to_start", 32'(alu_start), 32'd1);
        for (int i = 1; i <= 15; i++) begin
            tick();
            check("to_no_error_yet", 32'(error), 32'd0);
        end
        tick();
        check("to_error", 32'(error), 32'd1);
        check("to_estado", 32'(estado), 32'd3);
        press_exe();
        check("err_exit_estado", 32'(estado), 32'd0);
        check("err_exit_error", 32'(error), 32'd0);

        // Done on the last permitted cycle wins over timeout
        press_exe();
        press_exe();
        exe = 1'b1;
        tick();
        exe = 1'b0;
        for (int i = 1; i <= 15; i++) tick();
        alu_done = 1'b1;
        tick();
        alu_done = 1'b0;
        check("late_done_valid", 32'(result_valid), 32'd1);
        check("late_done_error", 32'(error), 32'd0);
        press_exe();

        // Simultaneous exe and button: exe wins, digit dropped
        press_digit(4'h3);
        digit_in = 4'h7;
        exe = 1'b1;
        button = 1'b1;
        tick();
        exe = 1'b0;
        button = 1'b0;
        tick();
        check("simul_estado", 32'(estado), 32'd1);
        check("simul_alu_a", 32'(alu_a), 32'h0003);
        check("simul_alu_b", 32'(alu_b), 32'd0);

        // Held button gives one digit; alu_done outside RUN ignored
        digit_in = 4'h9;
        button = 1'b1;
        repeat (10) tick();
        button = 1'b0;
        tick();
        check("held_alu_b", 32'(alu_b), 32'h0009);
        check("held_cnt", 32'(digit_cnt), 32'd1);
        alu_done = 1'b1;
        tick();
        alu_done = 1'b0;
        check("done_ignored", 32'(estado), 32'd1);

`ifdef CALC_SEQ_BACKSPACE_EN
        rst = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        press_digit(4'h1);
        press_digit(4'h2);
        press_digit(4'h3);
        del = 1'b1;
        tick();
        del = 1'b0;
        tick();
        check("bs_alu_a", 32'(alu_a), 32'h0012);
        check("bs_cnt", 32'(digit_cnt), 32'd2);
        press_exe();
        del = 1'b1;
        tick();
        del = 1'b0;
        tick();
        check("bs_empty_b", 32'(alu_b), 32'd0);
        check("bs_empty_cnt", 32'(digit_cnt), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
